encode_n_prio_rr: RTL
=====================

// Module: encode_n_prio_rr
// PURPOSE
//   Parametrised N-to-log2(N) encoder with enable, registered output and valid/ready handshake.
//   Modes: fixed priority (highest set index wins) or round-robin (rotating start pointer).
//   Sits between request sources and a single downstream consumer of the winning index.
//   Results are held stable under backpressure.
// PARAMETERS
//   N     8   number of request inputs, >= 2, power of two not required
//   MODE  0   0 = fixed priority, highest set index wins; 1 = round-robin
//   W     -   localparam = $clog2(N), width of encoded index
// PORTS
//   clk        in   1  single clock, all state updates on rising edge
//   rst        in   1  synchronous, active-high reset
//   en         in   1  sample request: x is sampled only when en=1
//   x          in   N  request vector; bit i = request from source i
//   out_ready  in   1  consumer accepts the current result this cycle
//   out_valid  out  1  y and none hold a result not yet accepted
//   y          out  W  encoded winning index; 0 when none=1
//   none       out  1  sampled x was all-zero
// BEHAVIOUR
//   - Reset (rst=1 at edge): out_valid=0, y=0, none=0, RR pointer ptr=0. Overrides all other inputs.
//     A held, unaccepted result is discarded.
//   - load = en & (~out_valid | out_ready).
//     On load: y<=winner(x,ptr), none<=(x==0), out_valid<=1. Latency is 1 cycle, x to y.
//   - No load and out_valid & out_ready: out_valid<=0. y and none keep their last value.
//   - out_valid & ~out_ready: y, none, out_valid, ptr frozen; x and en ignored.
//   - Accept and load in the same cycle: the new result replaces the old one and out_valid stays 1.
//     Full throughput is 1 result/cycle.
//   - MODE=0: winner = highest i with x[i]=1. ptr unused and stays 0.
//   - MODE=1: winner = lowest i >= ptr with x[i]=1.
//     If no set bit exists at or above ptr, scanning wraps and winner = lowest set i overall.
//   - MODE=1 pointer update on load with x!=0: ptr <= (winner==N-1) ? 0 : winner+1.
//     Wrap is at N-1, not 2^W-1.
//   - MODE=1, load with x==0: ptr unchanged.
//   - x==0 on load: y=0, none=1, out_valid=1. The consumer must check none.
//   - Width rules: ptr and y are W bits. All index arithmetic is unsigned, W+1 bits internally.
//     No index >= N is ever produced.
// STRUCTURE
//   - Package encode_pkg:
//     - MODE_FIXED=0, MODE_RR=1 constants.
//     - clog2-safe width function (W>=1 when N=2).
//   - Sub-module encode_prio_scan: purely combinational.
//     - Inputs x[N], ptr[W], mode.
//     - Outputs idx[W], none.
//     - Implements both scan orders, including wrap.
//   - Top level holds out_valid/y/none registers, ptr register and the load/accept logic.
// TESTING
//   1. Reset: rst=1 for 2 cycles, en=1, x=8'hFF, out_ready=1.
//      -> out_valid=0, y=0, none=0. First result after release is y=7 (MODE 0) or y=0 (MODE 1).
//   2. MODE 0: x=8'b0010_0110, en=1, out_ready=1.
//      -> next cycle y=5, none=0, out_valid=1. Then x=8'b0000_0001 -> y=0.
//   3. Backpressure: result y=5 held with out_ready=0 for 3 cycles while x changes.
//      -> y=5, out_valid=1 every cycle.
//      Raise out_ready with en=1, x=8'h08 -> next cycle y=3, out_valid stays 1.
//   4. MODE 1, x=8'hFF held, out_ready=1 -> y sequence 0,1,2,...,7,0,1; ptr wraps to 0 after 7.
//   5. MODE 1, ptr=6, x=8'b0000_0011 -> y=0, ptr=1; next load y=1, ptr=2.
//      N=5 build, x=5'b10000 -> y=4, ptr=0.
//   6. x=0, en=1 -> out_valid=1, none=1, y=0, ptr unchanged.
//      en=0 with out_ready=1 -> out_valid drops next cycle and y holds 0.
//      rst asserted while out_valid=1, out_ready=0 -> out_valid=0 next cycle.

Source files
------------

// File: rtl/encode_pkg.sv
// Shared constants and width helper for the priority / round-robin encoder.
package encode_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  // Index width that never collapses to zero, so N=2 still yields a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/encode_prio_scan.sv
// Combinational scan: highest-set-index (fixed) or lowest-at-or-above-ptr with wrap (round-robin).
module encode_prio_scan
  import encode_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] x,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         none
);

  logic [W-1:0] hi_idx;   // highest set bit overall
  logic [W-1:0] lo_idx;   // lowest set bit overall
  logic [W-1:0] rr_idx;   // lowest set bit at or above ptr
  logic         rr_any;

  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    rr_idx = '0;
    rr_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) hi_idx = W'(i);
    end
    // Descending walk so the last hit is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (x[i]) lo_idx = W'(i);
      if (x[i] && ((W+1)'(i) >= {1'b0, ptr})) begin
        rr_idx = W'(i);
        rr_any = 1'b1;
      end
    end
  end

  always_comb begin
    none = (x == '0);
    if (none) begin
      idx = '0;
    end else if (mode == MODE_RR[0]) begin
      idx = rr_any ? rr_idx : lo_idx;
    end else begin
      idx = hi_idx;
    end
  end

endmodule

// File: rtl/encode_n_prio_rr.sv
// N-to-log2(N) encoder with registered result, valid/ready handshake and optional round-robin.
module encode_n_prio_rr
  import encode_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned MODE = MODE_FIXED,
  localparam int unsigned W   = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] x,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] y,
  output logic         none
);

  localparam logic IsRr = (MODE == MODE_RR);

  logic         valid_q, valid_d;
  logic [W-1:0] y_q, y_d;
  logic         none_q, none_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic [W-1:0] win_idx;
  logic         win_none;
  logic [W:0]   ptr_inc;
  logic         load;

  encode_prio_scan #(
    .N (N),
    .W (W)
  ) u_scan (
    .x    (x),
    .ptr  (ptr_q),
    .mode (IsRr),
    .idx  (win_idx),
    .none (win_none)
  );

  assign load    = en & (~valid_q | out_ready);
  assign ptr_inc = {1'b0, win_idx} + (W+1)'(1);

  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    none_d  = none_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      y_d     = win_idx;
      none_d  = win_none;
      // Wrap at N-1 rather than 2^W-1 so non-power-of-two N never sees an invalid pointer.
      if (IsRr && !win_none) begin
        ptr_d = (win_idx == W'(N - 1)) ? '0 : W'(ptr_inc);
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      none_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      y_q     <= y_d;
      none_q  <= none_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign y         = y_q;
  assign none      = none_q;

endmodule
